// File: rtl/io_input_scanner.sv
// Round-robin input port scanner: samples one of four 32-bit ports per slot,
// latches changes, flags them in chg/irq, and exposes everything on a read map.
module io_scan_lane (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic        sample_i,
    input  logic        clr_i,
    input  logic [31:0] in_port_i,
    output logic [31:0] port_o,
    output logic        chg_o
);
    logic [31:0] port_q, port_d;
    logic        chg_q, chg_d;

    // A detected change overrides a concurrent read-clear so no event is lost.
    always_comb begin
        port_d = port_q;
        chg_d  = chg_q;
        if (clr_i) chg_d = 1'b0;
        if (sample_i && (in_port_i != port_q)) begin
            port_d = in_port_i;
            chg_d  = 1'b1;
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            port_q <= 32'h0;
            chg_q  <= 1'b0;
        end else begin
            port_q <= port_d;
            chg_q  <= chg_d;
        end
    end

    assign port_o = port_q;
    assign chg_o  = chg_q;
endmodule

module io_input_scanner #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic        io_clk,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic [31:0] in_port0,
    input  logic [31:0] in_port1,
    input  logic [31:0] in_port2,
    input  logic [31:0] in_port3,
    output logic [31:0] io_read_data,
    output logic [3:0]  chg,
    output logic        irq
);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_MAX = CW'(SCAN_DIV - 1);

    logic [CW-1:0]    div_cnt_q, div_cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             tick;
    logic             clr;
    logic [3:0][31:0] in_vec;
    logic [3:0][31:0] port_vec;
    logic [3:0]       chg_vec;
    logic             unused_addr;

    assign unused_addr = ^{addr[31:8], addr[1:0]};
    assign in_vec      = {in_port3, in_port2, in_port1, in_port0};
    assign tick        = (div_cnt_q == DIV_MAX);
    // The read returns every pending bit, so clearing all of them clears exactly those returned.
    assign clr         = rd && (addr[7:2] == 6'h24);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        ptr_d     = ptr_q;
        if (tick) begin
            div_cnt_d = '0;
            ptr_d     = ptr_q + 2'd1;
        end
    end

    always_ff @(posedge io_clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt_q <= '0;
            ptr_q     <= 2'd0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ptr_q     <= ptr_d;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        io_scan_lane u_lane (
            .io_clk    (io_clk),
            .resetn    (resetn),
            .sample_i  (tick && (ptr_q == 2'(g))),
            .clr_i     (clr),
            .in_port_i (in_vec[g]),
            .port_o    (port_vec[g]),
            .chg_o     (chg_vec[g])
        );
    end

    always_comb begin
        io_read_data = 32'h0;
        case (addr[7:2])
            6'h20:   io_read_data = port_vec[0];
            6'h21:   io_read_data = port_vec[1];
            6'h22:   io_read_data = port_vec[2];
            6'h23:   io_read_data = port_vec[3];
            6'h24:   io_read_data = {28'b0, chg_vec};
            6'h25:   io_read_data = {30'b0, ptr_q};
            default: io_read_data = 32'h0;
        endcase
    end

    assign chg = chg_vec;
    assign irq = |chg_vec;
endmodule

// File: tb/tb_io_input_scanner.sv
// Bench for io_input_scanner: SCAN_DIV=4 and SCAN_DIV=1 instances share stimulus
// and are compared every cycle against an arithmetic scan model.
module tb_io_input_scanner;
    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic        rd;
    logic [31:0] inp [4];
    logic [31:0] rdata [2];
    logic [3:0]  chg_o [2];
    logic        irq_o [2];

    int unsigned divs [2] = '{4, 1};
    int unsigned cnt_m [2];
    logic [31:0] port_m [2][4];
    logic [3:0]  chg_m [2];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_input_scanner #(.SCAN_DIV(4)) u_dut4 (
        .io_clk(clk), .resetn(resetn), .addr(addr), .rd(rd),
        .in_port0(inp[0]), .in_port1(inp[1]), .in_port2(inp[2]), .in_port3(inp[3]),
        .io_read_data(rdata[0]), .chg(chg_o[0]), .irq(irq_o[0]));

    io_input_scanner #(.SCAN_DIV(1)) u_dut1 (
        .io_clk(clk), .resetn(resetn), .addr(addr), .rd(rd),
        .in_port0(inp[0]), .in_port1(inp[1]), .in_port2(inp[2]), .in_port3(inp[3]),
        .io_read_data(rdata[1]), .chg(chg_o[1]), .irq(irq_o[1]));

    function automatic logic [31:0] model_read(int k, logic [31:0] a);
        logic [5:0] w;
        w = a[7:2];
        if (w >= 6'h20 && w <= 6'h23) return port_m[k][w - 6'h20];
        if (w == 6'h24) return {28'b0, chg_m[k]};
        if (w == 6'h25) return {30'b0, 2'((cnt_m[k] / divs[k]) % 4)};
        return 32'h0;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("chg[d%0d]", divs[k]), {28'b0, chg_o[k]}, {28'b0, chg_m[k]});
            check($sformatf("irq[d%0d]", divs[k]), {31'b0, irq_o[k]}, {31'b0, |chg_m[k]});
            check($sformatf("rdata[d%0d]@%h", divs[k], addr), rdata[k], model_read(k, addr));
        end
    endtask

    // One clock edge: model next state from pre-edge inputs, commit after the edge.
    task automatic step();
        logic [31:0] np [2][4];
        logic [3:0]  nc [2];
        int p;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) np[k][i] = port_m[k][i];
            nc[k] = chg_m[k];
            if (rd && addr[7:2] == 6'h24) nc[k] = 4'b0;
            if (cnt_m[k] % divs[k] == divs[k] - 1) begin
                p = (cnt_m[k] / divs[k]) % 4;
                if (inp[p] != port_m[k][p]) begin
                    np[k][p] = inp[p];
                    nc[k][p] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) port_m[k][i] = np[k][i];
            chg_m[k] = nc[k];
            cnt_m[k]++;
        end
        check_all();
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            cnt_m[k] = 0;
            chg_m[k] = 4'b0;
            for (int i = 0; i < 4; i++) port_m[k][i] = 32'h0;
        end
    endtask

    // Called 1 time unit after an edge; reset is applied and released between edges.
    task automatic do_reset();
        #1;
        resetn = 1'b0;
        #1;
        model_clear();
        check("rst_chg4", {28'b0, chg_o[0]}, 32'h0);
        check("rst_irq4", {31'b0, irq_o[0]}, 32'h0);
        check("rst_chg1", {28'b0, chg_o[1]}, 32'h0);
        check_all();
        #1;
        resetn = 1'b1;
    endtask

    task automatic set_addr(logic [31:0] a);
        addr = a;
        #1;
        check_all();
    endtask

    initial begin
        resetn = 1'b0;
        rd = 1'b0;
        addr = 32'h0;
        for (int i = 0; i < 4; i++) inp[i] = 32'h0;
        model_clear();
        #12;
        @(posedge clk);
        #1;
        do_reset();
        check_all();

        // Port 2 change is seen on the third tick of the divide-by-4 scanner
        inp[2] = 32'hA5A5_0001;
        repeat (11) step();
        check("p2_before_tick", {28'b0, chg_o[0]}, 32'h0);
        step();
        check("p2_chg", {28'b0, chg_o[0]}, 32'h4);
        check("p2_irq", {31'b0, irq_o[0]}, 32'h1);
        set_addr(32'h88);
        check("p2_read", rdata[0], 32'hA5A5_0001);

        // chg = 0101 then read-to-clear
        inp[0] = 32'h0000_1234;
        while (cnt_m[0] < 20) step();
        check("chg_0101", {28'b0, chg_o[0]}, 32'h5);
        set_addr(32'h90);
        check("rd90_data", rdata[0], 32'h5);
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("clr_chg", {28'b0, chg_o[0]}, 32'h0);
        check("clr_irq", {31'b0, irq_o[0]}, 32'h0);

        // Clear coinciding with a port-0 detect: set wins on bit 0
        inp[3] = 32'hDEAD_BEEF;
        step();
        while (cnt_m[0] % 16 != 3) step();
        check("p3_pending", {28'b0, chg_o[0]}, 32'h8);
        inp[0] = 32'h0000_5678;
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("set_wins", {28'b0, chg_o[0]}, 32'h1);

        // Reads elsewhere have no side effect
        rd = 1'b1;
        set_addr(32'h80);
        check("rd80", rdata[0], 32'h0000_5678);
        step();
        set_addr(32'h94);
        step();
        set_addr(32'h98);
        check("rd98", rdata[0], 32'h0);
        step();
        set_addr(32'h00);
        check("rd00", rdata[0], 32'h0);
        step();
        rd = 1'b0;
        check("no_side_eff", {28'b0, chg_o[0]}, 32'h1);

        // Glitch between two port-1 ticks is invisible
        addr = 32'h90;
        rd = 1'b1;
        step();
        rd = 1'b0;
        inp[1] = 32'h1;
        while (cnt_m[0] % 16 != 8) step();
        step();
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        check("p1_cleared", {28'b0, chg_o[0]}, 32'h0);
        inp[1] = 32'h2;
        step();
        step();
        inp[1] = 32'h1;
        step();
        while (cnt_m[0] % 16 != 8) step();
        check("glitch_chg1", {31'b0, chg_o[0][1]}, 32'h0);
        set_addr(32'h84);
        check("glitch_port1", rdata[0], 32'h1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 15) == 0) inp[i] = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
            rd = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: addr = 32'h80;
                1: addr = 32'h84;
                2: addr = 32'h88;
                3: addr = 32'h8C;
                4: addr = 32'h90;
                5: addr = 32'h94;
                6: addr = 32'h98;
                default: addr = $urandom;
            endcase
            #1;
            check_all();
            step();
        end
        rd = 1'b0;

        // Nonzero ports at reset release all flag; async reset mid-slot
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 4; i++) inp[i] = 32'h1111_0000 + i + 1;
        addr = 32'h94;
        repeat (16) step();
        check("all_chg", {28'b0, chg_o[0]}, 32'hF);
        step();
        step();
        do_reset();
        check("rst_ptr", rdata[0], 32'h0);

        // Divide-by-1: one port per cycle in order 0,1,2,3,0
        step();
        check("d1_s0", {28'b0, chg_o[1]}, 32'h1);
        step();
        check("d1_s1", {28'b0, chg_o[1]}, 32'h3);
        step();
        check("d1_s2", {28'b0, chg_o[1]}, 32'h7);
        step();
        check("d1_s3", {28'b0, chg_o[1]}, 32'hF);
        inp[0] = 32'hCAFE_0000;
        addr = 32'h80;
        step();
        check("d1_s4", rdata[1], 32'hCAFE_0000);
        check("d1_s4_ptr_unchanged_p1", {31'b0, chg_o[1][1]}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/io_input_scanner.md
IO_INPUT_SCANNER -- requirements
Module: io_input_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: io_clk cycles per port sample slot; legal range 1..256.
REQ-002 io_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 addr  in  32  CPU byte address; only addr[7:2] decoded.
REQ-005 rd  in  1  CPU read strobe, sampled on io_clk rising edge.
REQ-006 in_port0..in_port3  in  32 each  external input ports, asynchronous to nothing (io_clk domain).
REQ-007 io_read_data  out  32  combinational read data for current addr.
REQ-008 chg  out  4  per-port pending-change flags (bit N = port N).
REQ-009 irq  out  1  change-pending interrupt request.

Function
REQ-010 Slot counter div_cnt counts 0..SCAN_DIV-1, wraps to 0; a sample tick occurs in the cycle div_cnt == SCAN_DIV-1 (every cycle when SCAN_DIV = 1).
REQ-011 Port pointer ptr (2 bits) selects the port sampled on a tick; ptr increments by 1 after each tick, wrapping 3 -> 0.
REQ-012 On a tick, if in_port[ptr] differs from port_reg[ptr], port_reg[ptr] loads in_port[ptr] and chg[ptr] sets at the same edge; if equal, nothing changes.
REQ-013 Ports not addressed by ptr are never loaded; a port is re-sampled exactly every 4*SCAN_DIV cycles.
REQ-014 Worst-case latency from a stable input change to chg set: 4*SCAN_DIV cycles; glitches shorter than one slot between ticks are not seen.
REQ-015 Read map on addr[7:2]: 6'h20..6'h23 -> port_reg0..3 (byte 0x80/0x84/0x88/0x8C); 6'h24 (0x90) -> {28'b0, chg}; 6'h25 (0x94) -> {30'b0, ptr}; all other values -> 32'h0.
REQ-016 io_read_data is combinational from addr and registered state; zero-cycle read latency.
REQ-017 Read-to-clear: rd = 1 with addr[7:2] = 6'h24 clears at the next edge exactly the chg bits returned in that read.
REQ-018 Simultaneous clear and set of the same chg bit in one edge: set wins, bit stays 1.
REQ-019 rd to any address other than 0x90 has no side effect; reading port_reg never clears chg.
REQ-020 irq = OR of chg bits, driven from registered state, no combinational path from in_port*.
REQ-021 chg bit already set and a further change on that port: port_reg updates to newest value, chg stays 1 (no overflow count).

Reset
REQ-022 resetn low asynchronously forces div_cnt = 0, ptr = 0, port_reg0..3 = 32'h0, chg = 4'b0, irq = 0, independent of io_clk.
REQ-023 Reset mid-slot or mid-read aborts all activity; after resetn deasserts, the first tick occurs SCAN_DIV edges later and samples port 0.
REQ-024 A port holding a nonzero value at reset release produces chg set on its first tick.

Verification
REQ-025 SCAN_DIV=4, reset, in_port2 = 32'hA5A5_0001 stable -> chg = 4'b0100 and irq = 1 after the 12th edge (third tick); read 0x88 returns 32'hA5A5_0001.
REQ-026 chg = 4'b0101, rd at 0x90 -> io_read_data = 32'h5; next edge chg = 0, irq = 0.
REQ-027 Read at 0x90 in the same edge port 0 tick detects a change -> chg[0] remains 1, other returned bits clear.
REQ-028 In_port1 toggles 1->2->1 entirely between two port-1 ticks -> no chg[1], port_reg1 unchanged.
REQ-029 Reads of 0x80, 0x94, 0x98, 0x00 with rd = 1 -> port_reg0, ptr, 0, 0 respectively; chg unchanged.
REQ-030 resetn pulsed low mid-slot with chg = 4'hF -> outputs zero immediately without clock edge; ptr restarts at 0; SCAN_DIV=1 run shows one port sampled per cycle in order 0,1,2,3,0.
